// File: rtl/fsm_output_monitor.sv
// Protocol checker for the (x, y) output bus of the sequence-detector FSM.
// Tracks the producer state, counts s0->s1->s2 sequences, latches the first violation.
module fsm_output_monitor #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       x_in,
  input  logic             y_in,
  input  logic             sample,
  input  logic             clr,
  output logic [1:0]       state_o,
  output logic             seq_done,
  output logic [CNT_W-1:0] seq_cnt,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int unsigned DWELL_W = 8;

  localparam logic [2:0] TR_UNK = 3'd0;
  localparam logic [2:0] TR_S0  = 3'd1;
  localparam logic [2:0] TR_S1  = 3'd2;
  localparam logic [2:0] TR_S2  = 3'd3;
  localparam logic [2:0] TR_ERR = 3'd4;

  localparam logic [1:0] C_S0  = 2'd0;
  localparam logic [1:0] C_S1  = 2'd1;
  localparam logic [1:0] C_S2  = 2'd2;
  localparam logic [1:0] C_ILL = 2'd3;

  localparam logic [1:0] E_NONE  = 2'd0;
  localparam logic [1:0] E_CODE  = 2'd1;
  localparam logic [1:0] E_TRANS = 2'd2;
  localparam logic [1:0] E_TMO   = 2'd3;

  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_SAT   = {CNT_W{1'b1}};

  logic [2:0]         tracker_q, tracker_d;
  logic [1:0]         state_q, state_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         cls_c;

  // Classify the sampled output code.
  always_comb begin
    cls_c = C_ILL;
    if      (x_in == 2'd1 && !y_in) cls_c = C_S0;
    else if (x_in == 2'd0 &&  y_in) cls_c = C_S1;
    else if (x_in == 2'd3 &&  y_in) cls_c = C_S2;
  end

  // Tracker next-state and status next values.
  always_comb begin
    tracker_d = tracker_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    dwell_d   = dwell_q;
    done_d    = 1'b0;
    if (clr) begin
      tracker_d = TR_UNK;
      cnt_d     = '0;
      code_d    = E_NONE;
      dwell_d   = '0;
    end else if (sample && tracker_q != TR_ERR) begin
      if (cls_c == C_ILL) begin
        tracker_d = TR_ERR;
        code_d    = E_CODE;
      end else begin
        case (tracker_q)
          TR_UNK: begin
            if (cls_c == C_S0) tracker_d = TR_S0;
          end
          TR_S0: begin
            if (cls_c == C_S1) tracker_d = TR_S1;
            else if (cls_c == C_S2) begin
              tracker_d = TR_ERR;
              code_d    = E_TRANS;
            end
          end
          TR_S1: begin
            if (cls_c == C_S2) begin
              tracker_d = TR_S2;
              dwell_d   = DWELL_W'(1);
              done_d    = 1'b1;
              if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
            end else begin
              tracker_d = TR_ERR;
              code_d    = E_TRANS;
            end
          end
          TR_S2: begin
            if (cls_c == C_S0) begin
              tracker_d = TR_S0;
              dwell_d   = '0;
            end else if (cls_c == C_S1) begin
              tracker_d = TR_ERR;
              code_d    = E_TRANS;
            end else if (dwell_q < DWELL_MAX) begin
              dwell_d = dwell_q + DWELL_W'(1);
            end else begin
              tracker_d = TR_ERR;
              code_d    = E_TMO;
            end
          end
          default: begin
            tracker_d = TR_ERR;
          end
        endcase
      end
    end
  end

  // Visible state and error flag follow the next tracker value so outputs stay registered.
  always_comb begin
    state_d = 2'd3;
    case (tracker_d)
      TR_S0:   state_d = 2'd0;
      TR_S1:   state_d = 2'd1;
      TR_S2:   state_d = 2'd2;
      default: state_d = 2'd3;
    endcase
    err_d = (tracker_d == TR_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tracker_q <= TR_UNK;
      state_q   <= 2'd3;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      code_q    <= E_NONE;
      dwell_q   <= '0;
    end else begin
      tracker_q <= tracker_d;
      state_q   <= state_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      code_q    <= code_d;
      dwell_q   <= dwell_d;
    end
  end

  assign state_o  = state_q;
  assign seq_done = done_q;
  assign seq_cnt  = cnt_q;
  assign err      = err_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_fsm_output_monitor.sv
// Directed bench: default instance (a) plus a small instance (b, CNT_W=2, TIMEOUT=4) on shared inputs.
module tb_fsm_output_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] x_in;
  logic       y_in;
  logic       sample;
  logic       clr;

  logic [1:0] a_state, b_state;
  logic       a_done, b_done;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;
  logic       a_err, b_err;
  logic [1:0] a_code, b_code;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fsm_output_monitor #(.CNT_W(8), .TIMEOUT(16)) u_a (
    .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in), .sample(sample), .clr(clr),
    .state_o(a_state), .seq_done(a_done), .seq_cnt(a_cnt), .err(a_err), .err_code(a_code)
  );

  fsm_output_monitor #(.CNT_W(2), .TIMEOUT(4)) u_b (
    .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in), .sample(sample), .clr(clr),
    .state_o(b_state), .seq_done(b_done), .seq_cnt(b_cnt), .err(b_err), .err_code(b_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then return just after the capturing edge.
  task automatic step(input logic [1:0] x, input logic y, input logic s, input logic c);
    @(negedge clk);
    x_in = x; y_in = y; sample = s; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [1:0] x, input logic y);
    step(x, y, 1'b1, 1'b0);
  endtask

  task automatic do_clr();
    step(2'd0, 1'b0, 1'b0, 1'b1);
  endtask

  logic [1:0] sat_exp [5];

  initial begin
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
    rst = 1'b0; x_in = 2'd0; y_in = 1'b0; sample = 1'b0; clr = 1'b0;
    #23;
    chk("rst_state", 32'(a_state), 32'd3);
    chk("rst_done",  32'(a_done),  32'd0);
    chk("rst_cnt",   32'(a_cnt),   32'd0);
    chk("rst_err",   32'(a_err),   32'd0);
    chk("rst_code",  32'(a_code),  32'd0);
    @(negedge clk); rst = 1'b1;

    // Basic sequence s0 s1 s2 s0.
    smp(2'd1, 1'b0); chk("seq_s0", 32'(a_state), 32'd0);
    smp(2'd0, 1'b1); chk("seq_s1", 32'(a_state), 32'd1); chk("seq_s1_done", 32'(a_done), 32'd0);
    smp(2'd3, 1'b1); chk("seq_s2", 32'(a_state), 32'd2); chk("seq_s2_done", 32'(a_done), 32'd1);
    chk("seq_s2_cnt", 32'(a_cnt), 32'd1);
    smp(2'd1, 1'b0); chk("seq_back_s0", 32'(a_state), 32'd0); chk("seq_back_done", 32'(a_done), 32'd0);
    chk("seq_back_cnt", 32'(a_cnt), 32'd1); chk("seq_back_err", 32'(a_err), 32'd0);
    step(2'd1, 1'b0, 1'b0, 1'b0); chk("idle_hold", 32'(a_state), 32'd0);

    // Synchronisation: s2/s1 codes in UNK are tolerated.
    do_clr(); chk("clr_state", 32'(a_state), 32'd3); chk("clr_cnt", 32'(a_cnt), 32'd0);
    smp(2'd3, 1'b1); chk("unk_s2_state", 32'(a_state), 32'd3); chk("unk_s2_err", 32'(a_err), 32'd0);
    smp(2'd0, 1'b1); chk("unk_s1_state", 32'(a_state), 32'd3); chk("unk_s1_err", 32'(a_err), 32'd0);
    smp(2'd1, 1'b0); chk("unk_sync", 32'(a_state), 32'd0);

    // Illegal transition, stickiness, clr priority over sample.
    smp(2'd3, 1'b1); chk("s0s2_err", 32'(a_err), 32'd1); chk("s0s2_code", 32'(a_code), 32'd2);
    chk("s0s2_state", 32'(a_state), 32'd3);
    smp(2'd0, 1'b0); chk("sticky_code", 32'(a_code), 32'd2); chk("sticky_err", 32'(a_err), 32'd1);
    step(2'd1, 1'b0, 1'b1, 1'b1);
    chk("clrpri_state", 32'(a_state), 32'd3); chk("clrpri_err", 32'(a_err), 32'd0);
    chk("clrpri_code", 32'(a_code), 32'd0); chk("clrpri_cnt", 32'(a_cnt), 32'd0);

    // Illegal code in UNK, and illegal code beats transition check in S1.
    smp(2'd2, 1'b0); chk("unk_ill_code", 32'(a_code), 32'd1); chk("unk_ill_err", 32'(a_err), 32'd1);
    do_clr();
    smp(2'd1, 1'b0); smp(2'd0, 1'b1);
    smp(2'd1, 1'b1); chk("s1_ill_code", 32'(a_code), 32'd1);
    do_clr();

    // Timeout on b: four s2 samples fine, fifth errors.
    smp(2'd1, 1'b0); smp(2'd0, 1'b1);
    for (int i = 0; i < 4; i++) smp(2'd3, 1'b1);
    chk("tmo4_err", 32'(b_err), 32'd0); chk("tmo4_state", 32'(b_state), 32'd2);
    smp(2'd3, 1'b1);
    chk("tmo5_err", 32'(b_err), 32'd1); chk("tmo5_code", 32'(b_code), 32'd3);
    chk("tmo5_a_err", 32'(a_err), 32'd0); chk("tmo5_a_state", 32'(a_state), 32'd2);
    do_clr();

    // Timeout with idle gaps: gaps do not count toward dwell.
    smp(2'd1, 1'b0); smp(2'd0, 1'b1); smp(2'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(2'd3, 1'b1, 1'b0, 1'b0);
      step(2'd3, 1'b1, 1'b0, 1'b0);
      smp(2'd3, 1'b1);
    end
    chk("gap4_err", 32'(b_err), 32'd0); chk("gap4_state", 32'(b_state), 32'd2);
    step(2'd3, 1'b1, 1'b0, 1'b0); chk("gap_idle_err", 32'(b_err), 32'd0);
    smp(2'd3, 1'b1); chk("gap5_code", 32'(b_code), 32'd3);
    do_clr();

    // Saturation on b's 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      smp(2'd1, 1'b0); chk("sat_pre_done", 32'(b_done), 32'd0);
      smp(2'd0, 1'b1);
      smp(2'd3, 1'b1);
      chk("sat_done", 32'(b_done), 32'd1);
      chk("sat_cnt", 32'(b_cnt), 32'(sat_exp[i]));
    end
    smp(2'd1, 1'b0); chk("sat_end_done", 32'(b_done), 32'd0); chk("sat_end_cnt", 32'(b_cnt), 32'd3);
    chk("sat_a_cnt", 32'(a_cnt), 32'd5);
    do_clr();

    // Asynchronous reset while in S2 with two sequences counted.
    for (int i = 0; i < 2; i++) begin
      smp(2'd1, 1'b0); smp(2'd0, 1'b1); smp(2'd3, 1'b1);
      if (i == 0) smp(2'd1, 1'b0);
    end
    chk("pre_arst_state", 32'(b_state), 32'd2); chk("pre_arst_cnt", 32'(b_cnt), 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("arst_state", 32'(b_state), 32'd3); chk("arst_cnt", 32'(b_cnt), 32'd0);
    chk("arst_done", 32'(b_done), 32'd0); chk("arst_err", 32'(b_err), 32'd0);
    chk("arst_code", 32'(b_code), 32'd0); chk("arst_a_cnt", 32'(a_cnt), 32'd0);
    @(negedge clk); rst = 1'b1;
    smp(2'd1, 1'b0); chk("post_arst_s0", 32'(b_state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
